// File: rtl/sodor5_lb_core.sv
// sodor5_lb_core: five-stage RV32I-subset core with internal data
// memory and a single-entry load buffer exposed on observation ports.
package sodor5_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_COPY2 = 4'd10;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  wbaddr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [3:0]  alu_fun;
        logic        op2_imm;
        logic        ld;
        logic        st;
        logic        br;
        logic        bne;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  wbaddr;
        logic [31:0] alu_out;
        logic [31:0] rs2;
        logic        ld;
        logic        st;
    } ex_mem_t;

    typedef struct packed {
        logic [4:0]  wbaddr;
        logic [31:0] data;
    } mem_wb_t;

    localparam if_id_t IF_ID_NOP = '{pc: 32'd0, inst: NOP};

    localparam id_ex_t ID_EX_NOP = '{
        pc: 32'd0, inst: NOP, wbaddr: 5'd0,
        rs1: 32'd0, rs2: 32'd0, imm: 32'd0,
        alu_fun: ALU_ADD, op2_imm: 1'b0,
        ld: 1'b0, st: 1'b0, br: 1'b0, bne: 1'b0
    };

    localparam ex_mem_t EX_MEM_NOP = '{
        pc: 32'd0, inst: NOP, wbaddr: 5'd0,
        alu_out: 32'd0, rs2: 32'd0,
        ld: 1'b0, st: 1'b0
    };

endpackage

module sodor5_lb_core
    import sodor5_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic [31:0]   fe_in_io_imem_resp_bits_data,
    output logic [31:0]   fe_ou_io_imem_req_bits_addr,
    output logic          fe_ou_io_imem_req_valid,
    output logic [1023:0] port_regfile,
    output logic [31:0]   port_if_reg_pc,
    output logic [31:0]   port_dec_reg_pc,
    output logic [31:0]   port_exe_reg_pc,
    output logic [31:0]   port_mem_reg_pc,
    output logic [31:0]   port_dec_reg_inst,
    output logic [31:0]   port_exe_reg_inst,
    output logic [31:0]   port_mem_reg_inst,
    output logic [4:0]    port_dec_wbaddr,
    output logic [4:0]    port_exe_reg_wbaddr,
    output logic [4:0]    port_mem_reg_wbaddr,
    output logic [31:0]   port_imm,
    output logic [31:0]   port_imm_sbtype_sext,
    output logic [3:0]    port_alu_fun,
    output logic          port_mem_fcn,
    output logic [2:0]    port_mem_typ,
    output logic [4:0]    port_reg_rs1_addr_in,
    output logic [4:0]    port_reg_rs2_addr_in,
    output logic [31:0]   port_reg_rs1_data_out,
    output logic [31:0]   port_reg_rs2_data_out,
    output logic [31:0]   port_alu_out,
    output logic [31:0]   port_mem_reg_alu_out,
    output logic [4:0]    port_reg_rd_addr_in,
    output logic [31:0]   port_reg_rd_data_in,
    output logic          port_lb_table_valid,
    output logic [31:0]   port_lb_table_addr,
    output logic [31:0]   port_lb_table_data
);

    logic [31:0] if_reg_pc;
    if_id_t      dec_q;
    id_ex_t      exe_q;
    id_ex_t      dec_exe;
    ex_mem_t     mem_q;
    mem_wb_t     wb_q;

    logic [31:0] rf [0:31];
    logic [31:0] dmem [0:15];
    logic        lb_valid;
    logic [31:0] lb_addr;
    logic [31:0] lb_data;

    logic [31:0] di;
    logic [2:0]  f3;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic        is_opi;
    logic        is_op;
    logic        is_lui;
    logic        is_ld;
    logic        is_st;
    logic        is_br;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [31:0] imm_b;
    logic [31:0] dec_imm;
    logic [3:0]  dec_fun;
    logic [4:0]  dec_wbaddr;
    logic        use1;
    logic        use2;
    logic        stall;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] op2;
    logic [31:0] exe_alu;
    logic        br_taken;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wbdata;

    assign di     = dec_q.inst;
    assign f3     = di[14:12];
    assign rs1a   = di[19:15];
    assign rs2a   = di[24:20];
    assign is_opi = di[6:0] == 7'b0010011;
    assign is_op  = di[6:0] == 7'b0110011;
    assign is_lui = di[6:0] == 7'b0110111;
    assign is_ld  = di[6:0] == 7'b0000011;
    assign is_st  = di[6:0] == 7'b0100011;
    assign is_br  = di[6:0] == 7'b1100011 && f3[2:1] == 2'b00;

    assign imm_i = {{20{di[31]}}, di[31:20]};
    assign imm_s = {{20{di[31]}}, di[31:25], di[11:7]};
    assign imm_u = {di[31:12], 12'd0};
    assign imm_b = {{20{di[31]}}, di[7], di[30:25], di[11:8], 1'b0};
    assign dec_imm = is_st ? imm_s : (is_lui ? imm_u : imm_i);

    assign use1 = is_opi | is_op | is_ld | is_st | is_br;
    assign use2 = is_op | is_st | is_br;
    assign dec_wbaddr = (is_opi | is_op | is_lui | is_ld) ? di[11:7] : 5'd0;

    assign stall = exe_q.ld && exe_q.wbaddr != 5'd0 &&
                   ((use1 && rs1a == exe_q.wbaddr) ||
                    (use2 && rs2a == exe_q.wbaddr));

    assign mem_rdata  = dmem[mem_q.alu_out[5:2]];
    assign mem_wbdata = mem_q.ld ? mem_rdata : mem_q.alu_out;
    assign br_taken   = exe_q.br &&
                        ((exe_q.rs1 == exe_q.rs2) ^ exe_q.bne);

    // DEC ALU function select
    always_comb begin
        dec_fun = ALU_ADD;
        unique case (1'b1)
            is_lui: dec_fun = ALU_COPY2;
            is_br:  dec_fun = ALU_SUB;
            is_opi, is_op: begin
                case (f3)
                    3'd0: dec_fun = (is_op && di[30]) ? ALU_SUB : ALU_ADD;
                    3'd1: dec_fun = ALU_SLL;
                    3'd2: dec_fun = ALU_SLT;
                    3'd3: dec_fun = ALU_SLTU;
                    3'd4: dec_fun = ALU_XOR;
                    3'd5: dec_fun = di[30] ? ALU_SRA : ALU_SRL;
                    3'd6: dec_fun = ALU_OR;
                    3'd7: dec_fun = ALU_AND;
                endcase
            end
            default: dec_fun = ALU_ADD;
        endcase
    end

    // DEC operands with bypass, youngest producer first
    always_comb begin
        rs1_val = 32'd0;
        rs2_val = 32'd0;
        if (rs1a != 5'd0) begin
            if (exe_q.wbaddr == rs1a)      rs1_val = exe_alu;
            else if (mem_q.wbaddr == rs1a) rs1_val = mem_wbdata;
            else if (wb_q.wbaddr == rs1a)  rs1_val = wb_q.data;
            else                           rs1_val = rf[rs1a];
        end
        if (rs2a != 5'd0) begin
            if (exe_q.wbaddr == rs2a)      rs2_val = exe_alu;
            else if (mem_q.wbaddr == rs2a) rs2_val = mem_wbdata;
            else if (wb_q.wbaddr == rs2a)  rs2_val = wb_q.data;
            else                           rs2_val = rf[rs2a];
        end
    end

    // bundle decoded DEC state for EXE
    always_comb begin
        dec_exe = '{
            pc: dec_q.pc, inst: di, wbaddr: dec_wbaddr,
            rs1: rs1_val, rs2: rs2_val,
            imm: is_br ? imm_b : dec_imm,
            alu_fun: dec_fun,
            op2_imm: is_opi | is_lui | is_ld | is_st,
            ld: is_ld, st: is_st, br: is_br, bne: f3[0]
        };
    end

    // EXE ALU
    always_comb begin
        op2 = exe_q.op2_imm ? exe_q.imm : exe_q.rs2;
        exe_alu = exe_q.rs1 + op2;
        case (exe_q.alu_fun)
            ALU_SUB:   exe_alu = exe_q.rs1 - op2;
            ALU_SLL:   exe_alu = exe_q.rs1 << op2[4:0];
            ALU_SLT:   exe_alu = {31'd0, $signed(exe_q.rs1) < $signed(op2)};
            ALU_SLTU:  exe_alu = {31'd0, exe_q.rs1 < op2};
            ALU_XOR:   exe_alu = exe_q.rs1 ^ op2;
            ALU_SRL:   exe_alu = exe_q.rs1 >> op2[4:0];
            ALU_SRA:   exe_alu = $unsigned($signed(exe_q.rs1) >>> op2[4:0]);
            ALU_OR:    exe_alu = exe_q.rs1 | op2;
            ALU_AND:   exe_alu = exe_q.rs1 & op2;
            ALU_COPY2: exe_alu = op2;
            default:   exe_alu = exe_q.rs1 + op2;
        endcase
    end

    // pipeline advance, load-use stall and branch flush
    always_ff @(posedge clock) begin
        if (!reset) begin
            if_reg_pc <= 32'd0;
            dec_q     <= IF_ID_NOP;
            exe_q     <= ID_EX_NOP;
            mem_q     <= EX_MEM_NOP;
            wb_q      <= '{wbaddr: 5'd0, data: 32'd0};
        end else begin
            wb_q  <= '{wbaddr: mem_q.wbaddr, data: mem_wbdata};
            mem_q <= '{
                pc: exe_q.pc, inst: exe_q.inst, wbaddr: exe_q.wbaddr,
                alu_out: exe_alu, rs2: exe_q.rs2,
                ld: exe_q.ld, st: exe_q.st
            };
            if (br_taken) begin
                if_reg_pc <= exe_q.pc + exe_q.imm;
                dec_q     <= IF_ID_NOP;
                exe_q     <= ID_EX_NOP;
            end else if (stall) begin
                exe_q <= ID_EX_NOP;
            end else begin
                if_reg_pc <= if_reg_pc + 32'd4;
                dec_q <= '{pc: if_reg_pc, inst: fe_in_io_imem_resp_bits_data};
                exe_q <= dec_exe;
            end
        end
    end

    // register file write from WB; contents survive reset
    always_ff @(posedge clock) begin
        if (reset && wb_q.wbaddr != 5'd0)
            rf[wb_q.wbaddr] <= wb_q.data;
    end

    // data memory and load buffer update at end of MEM
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++)
                dmem[i] <= 32'd0;
            lb_valid <= 1'b0;
            lb_addr  <= 32'd0;
            lb_data  <= 32'd0;
        end else begin
            if (mem_q.st)
                dmem[mem_q.alu_out[5:2]] <= mem_q.rs2;
            if (mem_q.ld) begin
                lb_valid <= 1'b1;
                lb_addr  <= mem_q.alu_out;
                lb_data  <= mem_rdata;
            end else if (mem_q.st && lb_valid &&
                         lb_addr[31:2] == mem_q.alu_out[31:2]) begin
                lb_data <= mem_q.rs2;
            end
        end
    end

    // flatten register file, x0 field fixed at zero
    always_comb begin
        port_regfile = '0;
        for (int i = 1; i < 32; i++)
            port_regfile[32*i +: 32] = rf[i];
    end

    assign fe_ou_io_imem_req_bits_addr = if_reg_pc;
    assign fe_ou_io_imem_req_valid     = reset;
    assign port_if_reg_pc        = if_reg_pc;
    assign port_dec_reg_pc       = dec_q.pc;
    assign port_exe_reg_pc       = exe_q.pc;
    assign port_mem_reg_pc       = mem_q.pc;
    assign port_dec_reg_inst     = dec_q.inst;
    assign port_exe_reg_inst     = exe_q.inst;
    assign port_mem_reg_inst     = mem_q.inst;
    assign port_dec_wbaddr       = dec_wbaddr;
    assign port_exe_reg_wbaddr   = exe_q.wbaddr;
    assign port_mem_reg_wbaddr   = mem_q.wbaddr;
    assign port_imm              = dec_imm;
    assign port_imm_sbtype_sext  = imm_b;
    assign port_alu_fun          = dec_fun;
    assign port_mem_fcn          = is_st;
    assign port_mem_typ          = (is_ld | is_st) ? 3'd3 : 3'd0;
    assign port_reg_rs1_addr_in  = rs1a;
    assign port_reg_rs2_addr_in  = rs2a;
    assign port_reg_rs1_data_out = rs1_val;
    assign port_reg_rs2_data_out = rs2_val;
    assign port_alu_out          = exe_alu;
    assign port_mem_reg_alu_out  = mem_q.alu_out;
    assign port_reg_rd_addr_in   = wb_q.wbaddr;
    assign port_reg_rd_data_in   = wb_q.data;
    assign port_lb_table_valid   = lb_valid;
    assign port_lb_table_addr    = lb_addr;
    assign port_lb_table_data    = lb_data;

endmodule

// File: tb/tb_sodor5_lb_core.sv
// tb_sodor5_lb_core: directed pipeline timing checks plus random
// programs compared against an instruction-level reference model.
module tb_sodor5_lb_core;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int K_OPI = 0, K_OP = 1, K_LUI = 2, K_LD = 3;
    localparam int K_ST = 4, K_BR = 5, K_NOP = 6;

    typedef struct {
        int          k;
        int          rd;
        int          rs1;
        int          rs2;
        int          f3;
        bit          alt;
        logic [31:0] imm;
        logic [31:0] w;
    } ins_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   imem_data;
    logic [31:0]   imem_addr;
    logic          imem_valid;
    logic [1023:0] regfile;
    logic [31:0]   if_pc, dec_pc, exe_pc, mem_pc;
    logic [31:0]   dec_inst, exe_inst, mem_inst;
    logic [4:0]    dec_wb, exe_wb, mem_wb;
    logic [31:0]   imm, imm_sb;
    logic [3:0]    alu_fun;
    logic          mem_fcn;
    logic [2:0]    mem_typ;
    logic [4:0]    rs1_addr, rs2_addr, rd_addr;
    logic [31:0]   rs1_data, rs2_data, alu_out, mem_alu, rd_data;
    logic          lb_valid;
    logic [31:0]   lb_addr, lb_data;

    logic [31:0] rom [0:127];
    int          n_checks = 0;
    int          n_err = 0;

    ins_t        prog [$];
    logic [31:0] mr [0:31];
    logic [31:0] mm [0:15];
    logic        m_lbv;
    logic [31:0] m_lba, m_lbd;
    logic [31:0] saved [1:6];

    always #5 clock = ~clock;

    assign imem_data = (imem_addr[31:9] == '0) ? rom[imem_addr[8:2]] : NOP;

    sodor5_lb_core dut (
        .clock                        (clock),
        .reset                        (reset),
        .fe_in_io_imem_resp_bits_data (imem_data),
        .fe_ou_io_imem_req_bits_addr  (imem_addr),
        .fe_ou_io_imem_req_valid      (imem_valid),
        .port_regfile                 (regfile),
        .port_if_reg_pc               (if_pc),
        .port_dec_reg_pc              (dec_pc),
        .port_exe_reg_pc              (exe_pc),
        .port_mem_reg_pc              (mem_pc),
        .port_dec_reg_inst            (dec_inst),
        .port_exe_reg_inst            (exe_inst),
        .port_mem_reg_inst            (mem_inst),
        .port_dec_wbaddr              (dec_wb),
        .port_exe_reg_wbaddr          (exe_wb),
        .port_mem_reg_wbaddr          (mem_wb),
        .port_imm                     (imm),
        .port_imm_sbtype_sext         (imm_sb),
        .port_alu_fun                 (alu_fun),
        .port_mem_fcn                 (mem_fcn),
        .port_mem_typ                 (mem_typ),
        .port_reg_rs1_addr_in         (rs1_addr),
        .port_reg_rs2_addr_in         (rs2_addr),
        .port_reg_rs1_data_out        (rs1_data),
        .port_reg_rs2_data_out        (rs2_data),
        .port_alu_out                 (alu_out),
        .port_mem_reg_alu_out         (mem_alu),
        .port_reg_rd_addr_in          (rd_addr),
        .port_reg_rd_data_in          (rd_data),
        .port_lb_table_valid          (lb_valid),
        .port_lb_table_addr           (lb_addr),
        .port_lb_table_data           (lb_data)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] xreg(input int r);
        return regfile[32*r +: 32];
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op,
        input logic [2:0] f, input logic [4:0] rd, input logic [4:0] rs,
        input logic [11:0] im);
        return {im, rs, f, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7,
        input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f, input logic [4:0] rd);
        return {f7, rs2, rs1, f, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [2:0] f,
        input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] im);
        return {im[11:5], rs2, rs1, f, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] o);
        return {o[12], o[10:5], rs2, rs1, f, o[4:1], o[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] alu_ref(input int f, input bit alt,
        input logic [31:0] a, input logic [31:0] b);
        case (f)
            0: return alt ? a - b : a + b;
            1: return a << b[4:0];
            2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3: return (a < b) ? 32'd1 : 32'd0;
            4: return a ^ b;
            5: return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic ins_t gen(input int idx, input int last);
        ins_t x;
        int   sel, kw;
        logic [11:0] r12;
        x = '{k: K_NOP, rd: 0, rs1: 0, rs2: 0, f3: 0, alt: 1'b0,
              imm: 32'd0, w: NOP};
        sel = $urandom_range(0, 99);
        x.rd  = $urandom_range(0, 31);
        x.rs1 = $urandom_range(0, 31);
        x.rs2 = $urandom_range(0, 31);
        x.f3  = $urandom_range(0, 7);
        r12   = 12'($urandom);
        if (sel < 25) begin
            x.k = K_OPI;
            if (x.f3 == 1 || x.f3 == 5) begin
                x.alt = (x.f3 == 5) && $urandom_range(0, 1) == 1;
                r12 = {1'b0, x.alt, 5'd0, r12[4:0]};
            end
            x.imm = {{20{r12[11]}}, r12};
            x.w = enc_i(7'b0010011, 3'(x.f3), 5'(x.rd), 5'(x.rs1), r12);
        end else if (sel < 45) begin
            x.k = K_OP;
            x.alt = (x.f3 == 0 || x.f3 == 5) && $urandom_range(0, 1) == 1;
            x.w = enc_r({1'b0, x.alt, 5'd0}, 5'(x.rs2), 5'(x.rs1),
                        3'(x.f3), 5'(x.rd));
        end else if (sel < 52) begin
            x.k = K_LUI;
            x.imm = {20'($urandom), 12'd0};
            x.w = {x.imm[31:12], 5'(x.rd), 7'b0110111};
        end else if (sel < 67) begin
            x.k = K_LD;
            x.rs1 = 0;
            x.imm = 32'($urandom_range(0, 15) * 4);
            x.w = enc_i(7'b0000011, 3'(x.f3), 5'(x.rd), 5'd0, x.imm[11:0]);
        end else if (sel < 82) begin
            x.k = K_ST;
            x.rs1 = 0;
            x.imm = 32'($urandom_range(0, 15) * 4);
            x.w = enc_s(3'(x.f3), 5'(x.rs2), 5'd0, x.imm[11:0]);
        end else if (sel < 94) begin
            x.k = K_BR;
            x.f3 = $urandom_range(0, 1);
            x.rs1 = $urandom_range(0, 3);
            x.rs2 = ($urandom_range(0, 2) == 0) ? x.rs1 : $urandom_range(0, 3);
            kw = $urandom_range(1, 3);
            if (idx + kw > last) kw = last - idx;
            x.imm = 32'(kw * 4);
            x.w = enc_b(3'(x.f3), 5'(x.rs1), 5'(x.rs2), x.imm[12:0]);
        end else begin
            x.k = K_NOP;
            case ($urandom_range(0, 2))
                0: x.w = {25'($urandom), 7'b0010111};
                1: x.w = {25'($urandom), 7'b1101111};
                default: x.w = enc_b(3'd4, 5'd0, 5'd0, 13'd8);
            endcase
        end
        return x;
    endfunction

    task automatic model_run();
        int idx, steps, nxt;
        logic [31:0] a, b, ad, v;
        bit wr;
        for (int r = 0; r < 32; r++) mr[r] = 32'd0;
        for (int m = 0; m < 16; m++) mm[m] = 32'd0;
        m_lbv = 1'b0;
        m_lba = 32'd0;
        m_lbd = 32'd0;
        idx = 0;
        steps = 0;
        while (idx < prog.size() && steps < 1000) begin
            a = mr[prog[idx].rs1];
            b = mr[prog[idx].rs2];
            nxt = idx + 1;
            wr = 1'b0;
            v = 32'd0;
            case (prog[idx].k)
                K_OPI: begin
                    v = alu_ref(prog[idx].f3, prog[idx].alt, a, prog[idx].imm);
                    wr = 1'b1;
                end
                K_OP: begin
                    v = alu_ref(prog[idx].f3, prog[idx].alt, a, b);
                    wr = 1'b1;
                end
                K_LUI: begin
                    v = prog[idx].imm;
                    wr = 1'b1;
                end
                K_LD: begin
                    ad = a + prog[idx].imm;
                    v = mm[ad[5:2]];
                    wr = 1'b1;
                    m_lbv = 1'b1;
                    m_lba = ad;
                    m_lbd = v;
                end
                K_ST: begin
                    ad = a + prog[idx].imm;
                    mm[ad[5:2]] = b;
                    if (m_lbv && m_lba[31:2] == ad[31:2]) m_lbd = b;
                end
                K_BR: begin
                    if ((prog[idx].f3 == 0) ? (a == b) : (a != b))
                        nxt = idx + int'(prog[idx].imm) / 4;
                end
                default: ;
            endcase
            if (wr && prog[idx].rd != 0) mr[prog[idx].rd] = v;
            idx = nxt;
            steps++;
        end
    endtask

    initial begin
        logic [31:0] i_x2, i_sw, i_lw, i_x4, i_beq, i_x1;
        int last;
        ins_t t;

        i_x1  = enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd5);
        i_x2  = enc_i(7'h13, 3'd0, 5'd2, 5'd1, 12'd3);
        i_sw  = enc_s(3'd2, 5'd1, 5'd0, 12'd4);
        i_lw  = enc_i(7'h03, 3'd2, 5'd3, 5'd0, 12'd4);
        i_x4  = enc_i(7'h13, 3'd0, 5'd4, 5'd3, 12'd1);
        i_beq = enc_b(3'd0, 5'd0, 5'd0, 13'd8);
        for (int i = 0; i < 128; i++) rom[i] = NOP;
        rom[0] = enc_i(7'h13, 3'd0, 5'd5, 5'd0, 12'd9);
        rom[1] = i_x1;
        rom[2] = i_x2;
        rom[3] = i_sw;
        rom[4] = i_lw;
        rom[5] = i_x4;
        rom[6] = i_beq;
        rom[7] = enc_i(7'h13, 3'd0, 5'd5, 5'd0, 12'd1);
        rom[8] = enc_i(7'h13, 3'd0, 5'd6, 5'd0, 12'd2);
        rom[9] = enc_b(3'd0, 5'd0, 5'd0, 13'd0);

        reset = 1'b0;
        tick(2);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_dec_inst", dec_inst, NOP);
        chk("rst_exe_inst", exe_inst, NOP);
        chk("rst_mem_inst", mem_inst, NOP);
        chk("rst_wb", {exe_wb, mem_wb}, 32'd0);
        chk("rst_lbv", lb_valid, 1'b0);
        chk("rst_lba", lb_addr, 32'd0);
        chk("rst_lbd", lb_data, 32'd0);
        chk("rst_req_valid", imem_valid, 1'b0);
        reset = 1'b1;

        for (int c = 0; c < 40; c++) begin
            case (c)
                0: begin
                    chk("req_valid", imem_valid, 1'b1);
                    chk("pc0", if_pc, 32'd0);
                end
                1: chk("pc1", if_pc, 32'd4);
                2: chk("pc2", if_pc, 32'd8);
                3: begin
                    chk("c3_dec", dec_inst, i_x2);
                    chk("byp_exe", rs1_data, 32'd5);
                    chk("c3_alu", alu_out, 32'd5);
                end
                4: begin
                    chk("nostall_exe", exe_inst, i_x2);
                    chk("sw_fcn", mem_fcn, 1'b1);
                    chk("sw_imm", imm, 32'd4);
                    chk("byp_mem", rs2_data, 32'd5);
                    chk("c4_pcs", {dec_pc[7:0], exe_pc[7:0], mem_pc[7:0]},
                        32'h000c_0804);
                    chk("c4_wb", {exe_wb, mem_wb}, {22'd0, 5'd2, 5'd1});
                    chk("c4_mem_inst", mem_inst, i_x1);
                    chk("c4_mem_alu", mem_alu, 32'd5);
                end
                5: begin
                    chk("lw_typ", mem_typ, 3'd3);
                    chk("lw_fcn", mem_fcn, 1'b0);
                    chk("wb_port", {rd_addr, rd_data[26:0]},
                        {5'd1, 27'd5});
                end
                6: begin
                    chk("x1_t5", xreg(1), 32'd5);
                    chk("lu_exe", exe_inst, i_lw);
                    chk("lu_dec_wb", dec_wb, 5'd4);
                    chk("lu_rs1", rs1_addr, 5'd3);
                    chk("lu_fun", alu_fun, 4'd0);
                end
                7: begin
                    chk("bubble_exe", exe_inst, NOP);
                    chk("bubble_wb", exe_wb, 5'd0);
                    chk("stall_dec", dec_inst, i_x4);
                    chk("stall_pc", if_pc, 32'd24);
                    chk("byp_load", rs1_data, 32'd5);
                    chk("pre_lbv", lb_valid, 1'b0);
                end
                8: begin
                    chk("lb_valid", lb_valid, 1'b1);
                    chk("lb_addr", lb_addr, 32'd4);
                    chk("lb_data", lb_data, 32'd5);
                    chk("beq_sb", imm_sb, 32'd8);
                    chk("beq_rs2", rs2_addr, 5'd0);
                end
                10: begin
                    chk("br_pc", if_pc, 32'd32);
                    chk("flush_dec", dec_inst, NOP);
                    chk("flush_exe", exe_inst, NOP);
                end
                default: ;
            endcase
            tick(1);
        end
        chk("x0", xreg(0), 32'd0);
        chk("x1", xreg(1), 32'd5);
        chk("x2", xreg(2), 32'd8);
        chk("x3", xreg(3), 32'd5);
        chk("x4", xreg(4), 32'd6);
        chk("x5", xreg(5), 32'd9);
        chk("x6", xreg(6), 32'd2);
        for (int r = 1; r <= 6; r++) saved[r] = xreg(r);

        reset = 1'b0;
        tick(1);
        chk("mid_lbv", lb_valid, 1'b0);
        chk("mid_lba", lb_addr, 32'd0);
        chk("mid_lbd", lb_data, 32'd0);
        chk("mid_pc", if_pc, 32'd0);
        chk("mid_dec", dec_inst, NOP);
        for (int r = 1; r <= 6; r++)
            chk($sformatf("mid_x%0d", r), xreg(r), saved[r]);

        for (int it = 0; it < 6; it++) begin
            reset = 1'b0;
            prog.delete();
            for (int r = 1; r < 32; r++) begin
                t = '{k: K_OPI, rd: r, rs1: 0, rs2: 0, f3: 0, alt: 1'b0,
                      imm: 32'd0, w: NOP};
                t.imm = 32'($signed(12'($urandom)));
                t.w = enc_i(7'h13, 3'd0, 5'(r), 5'd0, t.imm[11:0]);
                prog.push_back(t);
            end
            last = 31 + 40;
            for (int n = 31; n < last; n++) prog.push_back(gen(n, last));
            for (int i = 0; i < 128; i++) rom[i] = NOP;
            foreach (prog[i]) rom[i] = prog[i].w;
            rom[last] = enc_b(3'd0, 5'd0, 5'd0, 13'd0);
            model_run();
            tick(2);
            reset = 1'b1;
            tick(350);
            chk($sformatf("r%0d_x0", it), xreg(0), 32'd0);
            for (int r = 1; r < 32; r++)
                chk($sformatf("r%0d_x%0d", it, r), xreg(r), mr[r]);
            chk($sformatf("r%0d_lbv", it), lb_valid, m_lbv);
            chk($sformatf("r%0d_lba", it), lb_addr, m_lba);
            chk($sformatf("r%0d_lbd", it), lb_data, m_lbd);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
